// File: rtl/vga_char_writer_if.sv
// CPU display port and video RAM port bundle for vga_char_writer.
// master = byte source / video RAM side, slave = the writer itself.
interface vga_char_writer_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        din;
  logic              din_valid;
  logic              din_ready;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_wr;
  logic [5:0]        vram_wdata;
  logic [5:0]        vram_rdata;
  logic [5:0]        cursor_x;
  logic [4:0]        cursor_y;
  logic              busy;

  modport master (
    output din, din_valid, vram_rdata,
    input  din_ready, vram_addr, vram_wr, vram_wdata, cursor_x, cursor_y, busy
  );

  modport slave (
    input  din, din_valid, vram_rdata,
    output din_ready, vram_addr, vram_wr, vram_wdata, cursor_x, cursor_y, busy
  );
endinterface

// File: rtl/vga_char_writer.sv
// Terminal writer for the 40x24 character buffer: cursor, wrap, CR and scroll.
// Optional: define CHAR_WRITER_CLS_EN to make form feed (0x0C) clear the screen.
//
// state     | meaning
// CLEAR     | fill every cell with space, cursor home
// IDLE      | din_ready high, waiting for a byte
// WRITE     | glyph write strobe on the bus
// NEWLINE   | cursor to column 0, next row or start scroll
// SCR_RD    | present source cell (one row below) for read
// SCR_WR    | write read data one row up
// SCR_BLANK | fill last row with space
module vga_char_writer #(
  parameter int COLS   = 40,
  parameter int ROWS   = 24,
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  vga_char_writer_if.slave   bus
);

  localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(COLS*ROWS - 1);
  localparam logic [ADDR_W-1:0] BLANK_BASE = ADDR_W'(COLS*(ROWS - 1));
  localparam logic [5:0]        LAST_X     = 6'(COLS - 1);
  localparam logic [4:0]        LAST_Y     = 5'(ROWS - 1);
  localparam logic [5:0]        SPACE      = 6'h20;

  typedef enum logic [2:0] {CLEAR, IDLE, WRITE, NEWLINE, SCR_RD, SCR_WR, SCR_BLANK} state_t;

  state_t            state;
  logic [ADDR_W-1:0] vram_addr;
  logic [ADDR_W-1:0] rowbase;
  logic [ADDR_W-1:0] src;
  logic              vram_wr;
  logic [5:0]        wdata_q;
  logic [5:0]        cursor_x;
  logic [4:0]        cursor_y;
  logic              din_ready;
  logic [7:0]        ch;
  logic              printable;

  always_comb begin
    ch = bus.din & 8'h7F;
    if (ch >= 8'h60) ch = ch - 8'h20;
    printable = (ch >= 8'h20) && (ch <= 8'h5F);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      vram_addr <= '0;
      vram_wr   <= 1'b0;
      wdata_q   <= '0;
      cursor_x  <= '0;
      cursor_y  <= '0;
      rowbase   <= '0;
      src       <= '0;
      din_ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cursor_x <= '0;
          cursor_y <= '0;
          rowbase  <= '0;
          wdata_q  <= SPACE;
          // Coming out of reset the strobe is still low: start the sweep at cell 0.
          if (!vram_wr) begin
            vram_wr   <= 1'b1;
            vram_addr <= '0;
          end else if (vram_addr == LAST_A) begin
            vram_wr <= 1'b0;
            state   <= IDLE;
          end else begin
            vram_addr <= vram_addr + 1'b1;
          end
        end
        IDLE: begin
          din_ready <= 1'b1;
          if (bus.din_valid && din_ready) begin
            din_ready <= 1'b0;
            if (printable) begin
              state     <= WRITE;
              vram_wr   <= 1'b1;
              vram_addr <= rowbase + ADDR_W'(cursor_x);
              wdata_q   <= ch[5:0];
            end else if (ch == 8'h0D) begin
              state <= NEWLINE;
            end
`ifdef CHAR_WRITER_CLS_EN
            else if (ch == 8'h0C) begin
              state     <= CLEAR;
              vram_wr   <= 1'b1;
              vram_addr <= '0;
              wdata_q   <= SPACE;
            end
`endif
          end
        end
        WRITE: begin
          vram_wr <= 1'b0;
          if (cursor_x == LAST_X) begin
            state <= NEWLINE;
          end else begin
            cursor_x <= cursor_x + 1'b1;
            state    <= IDLE;
          end
        end
        NEWLINE: begin
          cursor_x <= '0;
          if (cursor_y != LAST_Y) begin
            cursor_y <= cursor_y + 1'b1;
            rowbase  <= rowbase + COLS_A;
            state    <= IDLE;
          end else begin
            src       <= COLS_A;
            vram_addr <= COLS_A;
            state     <= SCR_RD;
          end
        end
        SCR_RD: begin
          vram_wr   <= 1'b1;
          vram_addr <= src - COLS_A;
          state     <= SCR_WR;
        end
        SCR_WR: begin
          if (src == LAST_A) begin
            vram_addr <= BLANK_BASE;
            wdata_q   <= SPACE;
            state     <= SCR_BLANK;
          end else begin
            vram_wr   <= 1'b0;
            src       <= src + 1'b1;
            vram_addr <= src + 1'b1;
            state     <= SCR_RD;
          end
        end
        SCR_BLANK: begin
          if (vram_addr == LAST_A) begin
            vram_wr <= 1'b0;
            state   <= IDLE;
          end else begin
            vram_addr <= vram_addr + 1'b1;
          end
        end
        default: begin
          vram_wr <= 1'b0;
          state   <= CLEAR;
        end
      endcase
    end
  end

  // Read data lands the cycle after SCR_RD, so the scroll copy forwards it straight to the port.
  assign bus.vram_wdata = (state == SCR_WR) ? bus.vram_rdata : wdata_q;
  assign bus.vram_addr  = vram_addr;
  assign bus.vram_wr    = vram_wr;
  assign bus.din_ready  = din_ready;
  assign bus.cursor_x   = cursor_x;
  assign bus.cursor_y   = cursor_y;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_vga_char_writer.sv
// Bench for vga_char_writer: video RAM model, screen/cursor reference model,
// per-cycle compare process and directed byte sequences.
module tb_vga_char_writer;
  localparam int COLS  = 40;
  localparam int ROWS  = 24;
  localparam int CELLS = COLS * ROWS;
`ifdef CHAR_WRITER_CLS_EN
  localparam int CLS_BUSY = CELLS;
`else
  localparam int CLS_BUSY = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  vga_char_writer_if #(.ADDR_W(10)) bus();

  vga_char_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(10)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [5:0] mem [0:1023];
  int         cyc = 0;
  int         n_wr = 0;
  int         last_wr_edge = 0;
  logic [9:0] last_addr = '0;
  logic [5:0] last_data = '0;

  // Synchronous video RAM: read data valid the cycle after a non-write address.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.vram_wr) begin
      mem[bus.vram_addr] <= bus.vram_wdata;
      n_wr         <= n_wr + 1;
      last_addr    <= bus.vram_addr;
      last_data    <= bus.vram_wdata;
      last_wr_edge <= cyc + 1;
    end else begin
      bus.vram_rdata <= mem[bus.vram_addr];
    end
  end

  int screen [CELLS];
  int mx = 0;
  int my = 0;
  int acc_edge = 0;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) screen[i] = 32;
    mx = 0;
    my = 0;
  endtask

  task automatic model_newline();
    mx = 0;
    if (my < ROWS - 1) my++;
    else begin
      for (int i = 0; i < CELLS - COLS; i++) screen[i] = screen[i + COLS];
      for (int i = CELLS - COLS; i < CELLS; i++) screen[i] = 32;
    end
  endtask

  task automatic model_apply(input logic [7:0] raw);
    int b;
    b = int'(raw) & 'h7F;
    if (b >= 'h60) b = b - 'h20;
    if (b >= 'h20 && b <= 'h5F) begin
      screen[my * COLS + mx] = b % 64;
      if (mx == COLS - 1) model_newline();
      else mx++;
    end else if (b == 'h0D) begin
      model_newline();
    end
`ifdef CHAR_WRITER_CLS_EN
    else if (b == 'h0C) begin
      model_clear();
    end
`endif
  endtask

  task automatic cmp_screen(input string name);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int i = 0; i < CELLS; i++) begin
      if (int'(mem[i]) !== screen[i]) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d cells differ, first at %0d got %0d expected %0d",
               name, bad, first, mem[first], screen[first]);
    end
  endtask

  task automatic wait_ready(input int limit);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.din_ready && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (!bus.din_ready) check("ready_timeout", int'(bus.din_ready), 1);
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.din_ready && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.din_ready) check("send_timeout", int'(bus.din_ready), 1);
    bus.din       = b;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    acc_edge = cyc;
    model_apply(b);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 4000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Compare process: guards on the write strobe and cursor whenever the writer is idle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.vram_wr) begin
        tests++;
        if (bus.vram_addr >= CELLS || bus.din_ready) begin
          fails++;
          $display("FAIL wr_guard: addr %0d din_ready %0d while writing", bus.vram_addr, bus.din_ready);
        end
      end
      if (bus.din_ready) begin
        tests++;
        if (bus.cursor_x != mx || bus.cursor_y != my || bus.busy) begin
          fails++;
          $display("FAIL idle_cursor: got (%0d,%0d) busy %0d expected (%0d,%0d) busy 0",
                   bus.cursor_x, bus.cursor_y, bus.busy, mx, my);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, %0d tests run %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    int n;
    int w;
    bus.din       = 8'h00;
    bus.din_valid = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wr", int'(bus.vram_wr), 0);
    check("rst_addr", int'(bus.vram_addr), 0);
    check("rst_wdata", int'(bus.vram_wdata), 0);
    check("rst_ready", int'(bus.din_ready), 0);
    check("rst_busy", int'(bus.busy), 1);
    check("rst_cursor", int'(bus.cursor_x) + int'(bus.cursor_y), 0);
    model_clear();
    reset = 1'b0;

    // Power-up clear
    wait_ready(2000);
    check("clr_count", n_wr, 960);
    check("clr_last_addr", int'(last_addr), 959);
    check("clr_last_data", int'(last_data), 32);
    check("clr_cursor", int'(bus.cursor_x) * 100 + int'(bus.cursor_y), 0);
    cmp_screen("clr_screen");

    // 'A' with bit 7 set
    send(8'hC1);
    wait_ready(20);
    check("a_addr", int'(last_addr), 0);
    check("a_data", int'(last_data), 1);
    check("a_wr_latency", last_wr_edge - acc_edge, 1);
    check("a_ready_latency", cyc - acc_edge, 2);
    check("a_cursor_x", int'(bus.cursor_x), 1);

    // lower-case fold, then BEL ignored
    send(8'h61);
    wait_ready(20);
    check("fold_addr", int'(last_addr), 1);
    check("fold_data", int'(last_data), 1);
    w = n_wr;
    send(8'h07);
    wait_ready(20);
    check("bel_no_write", n_wr, w);
    check("bel_cursor_x", int'(bus.cursor_x), 2);

    // CR then a full row of '0' on row 1: wraps to row 2 without scrolling
    send(8'h0D);
    wait_ready(20);
    for (int i = 0; i < COLS; i++) begin
      send(8'hB0);
      wait_ready(20);
    end
    check("row_last_addr", int'(last_addr), 79);
    check("row_last_data", int'(last_data), 'h30);
    check("row_cursor", int'(bus.cursor_x) * 100 + int'(bus.cursor_y), 2);
    send(8'h7B);
    wait_ready(20);
    send(8'h7F);
    wait_ready(20);
    send(8'h1F);
    wait_ready(20);
    send(8'h20);
    wait_ready(20);
    cmp_screen("mixed_screen");

    // Fill row r with code r; the last wrap on row 23 scrolls the screen
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    model_clear();
    wait_ready(2000);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        send(8'(8'h40 + r + ((c % 2) * 8'h80)));
        wait_ready(3000);
      end
    end
    cmp_screen("wrap_scroll_screen");
    check("wrap_m0", int'(mem[0]), 1);
    check("wrap_m879", int'(mem[879]), 22);
    check("wrap_m880", int'(mem[880]), 23);
    check("wrap_m959", int'(mem[959]), 32);
    check("wrap_cursor", int'(bus.cursor_x) * 100 + int'(bus.cursor_y), 23);

    // CR on the last row: one NEWLINE cycle then 1880 scroll cycles
    send(8'h8D);
    count_busy(n);
    check("scroll_busy", n, 1881);
    wait_ready(20);
    cmp_screen("cr_scroll_screen");
    check("cr_m0", int'(mem[0]), 2);
    check("cr_m840", int'(mem[840]), 23);
    check("cr_m880", int'(mem[880]), 32);

    // Form feed
    send(8'h48);
    wait_ready(20);
    w = n_wr;
    send(8'h0C);
    count_busy(n);
    check("ff_busy", n, CLS_BUSY);
    check("ff_writes", n_wr - w, CLS_BUSY);
    wait_ready(20);
    cmp_screen("ff_screen");

    // Reset in the middle of a scroll restarts the clear from cell 0
    while (my != ROWS - 1) begin
      send(8'h0D);
      wait_ready(20);
    end
    send(8'h0D);
    repeat (700) @(negedge clk);
    check("mid_busy", int'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_wr", int'(bus.vram_wr), 0);
    check("mid_rst_ready", int'(bus.din_ready), 0);
    w = n_wr;
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 10 && n_wr == w; i++) @(negedge clk);
    check("mid_first_addr", int'(last_addr), 0);
    wait_ready(2000);
    check("mid_clr_count", n_wr - w, 960);
    cmp_screen("mid_screen");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
